// File: rtl/signed_mult_sequencer_pkg.sv
// Shared constants for the sequential signed multiplier: FSM state encodings,
// default operand sizing and the CPU opcode that selects the multiply path.
package signed_mult_sequencer_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 4;

    // FSM state encodings (3-bit, fixed values visible to debug tooling)
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_NEG_IN  = 3'd1;
    localparam logic [2:0] S_ITER    = 3'd2;
    localparam logic [2:0] S_NEG_OUT = 3'd3;
    localparam logic [2:0] S_FINISH  = 3'd4;

    // Opcode decoded by the CPU control unit to launch a multiply
    localparam logic [6:0] OPC_MULT = 7'b0110011;

endpackage

// File: rtl/signed_mult_sequencer_if.sv
// Handshake and data bundle between the CPU ALU path (master) and the
// multiplier sequencer (slave).
interface signed_mult_sequencer_if
    import signed_mult_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic                   start;
    logic [WIDTH-1:0]       opa;
    logic [WIDTH-1:0]       opb;
    logic [2*WIDTH-1:0]     product;
    logic [WIDTH-1:0]       result;
    logic                   overflow;
    logic                   busy;
    logic                   done;

    modport master (
        output start, opa, opb,
        input  product, result, overflow, busy, done
    );

    modport slave (
        input  start, opa, opb,
        output product, result, overflow, busy, done
    );
endinterface

// File: rtl/signed_mult_sequencer_negate.sv
// Combinational two's-complement negator, width-generic.
module mult_negate #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] out_o
);
    assign out_o = ~in_i + {{(WIDTH-1){1'b0}}, 1'b1};
endmodule

// File: rtl/signed_mult_sequencer.sv
// Sign-magnitude sequential multiplier: negate negative operands, run WIDTH
// shift-and-add iterations, then negate the product when operand signs differ.
// BUSY stalls the CPU PC for the whole operation; DONE pulses with the result.
module signed_mult_sequencer
    import signed_mult_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    signed_mult_sequencer_if.slave  mul_if
);
    localparam int PW = 2 * WIDTH;

    logic [2:0]       state_q,   state_d;
    logic [PW-1:0]    mcand_q,   mcand_d;
    logic [WIDTH-1:0] mplier_q,  mplier_d;
    logic [PW-1:0]    acc_q,     acc_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             sign_q,    sign_d;
    logic [PW-1:0]    product_q, product_d;
    logic             ovf_q,     ovf_d;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] mcand_neg_s;
    logic [WIDTH-1:0] mplier_neg_s;
    logic [PW-1:0]    acc_neg_s;
    logic [PW-1:0]    prod_s;

    // True when the product does not fit in a signed WIDTH-bit value:
    // the top WIDTH+1 bits must be a pure sign extension.
    function automatic logic ovf_check(input logic [PW-1:0] p);
        logic [WIDTH:0] upper;
        upper = p[PW-1:WIDTH-1];
        return ~((&upper) | (~|upper));
    endfunction

    mult_negate #(.WIDTH(WIDTH)) u_neg_mcand (
        .in_i  (mcand_q[WIDTH-1:0]),
        .out_o (mcand_neg_s)
    );

    mult_negate #(.WIDTH(WIDTH)) u_neg_mplier (
        .in_i  (mplier_q),
        .out_o (mplier_neg_s)
    );

    mult_negate #(.WIDTH(PW)) u_neg_prod (
        .in_i  (acc_q),
        .out_o (acc_neg_s)
    );

    // Next-state and datapath decode for the multiply sequence
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        product_d = product_q;
        ovf_d     = ovf_q;

        if (sign_q) begin
            prod_s = acc_neg_s;
        end else begin
            prod_s = acc_q;
        end

        case (state_q)
            S_IDLE: begin
                if (mul_if.start) begin
                    mcand_d  = {{WIDTH{1'b0}}, mul_if.opa};
                    mplier_d = mul_if.opb;
                    sign_d   = mul_if.opa[WIDTH-1] ^ mul_if.opb[WIDTH-1];
                    state_d  = S_NEG_IN;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_NEG_IN: begin
                // Magnitudes are unsigned, so 0x80 stays 0x80 (i.e. 128)
                if (mcand_q[WIDTH-1]) begin
                    mcand_d = {{WIDTH{1'b0}}, mcand_neg_s};
                end else begin
                    mcand_d = mcand_q;
                end
                if (mplier_q[WIDTH-1]) begin
                    mplier_d = mplier_neg_s;
                end else begin
                    mplier_d = mplier_q;
                end
                acc_d   = {PW{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
                state_d = S_ITER;
            end
            S_ITER: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = {mcand_q[PW-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_NEG_OUT;
                end else begin
                    state_d = S_ITER;
                end
            end
            S_NEG_OUT: begin
                product_d = prod_s;
                ovf_d     = ovf_check(prod_s);
                state_d   = S_FINISH;
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            mcand_q   <= {PW{1'b0}};
            mplier_q  <= {WIDTH{1'b0}};
            acc_q     <= {PW{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            sign_q    <= 1'b0;
            product_q <= {PW{1'b0}};
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            product_q <= product_d;
            ovf_q     <= ovf_d;
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_d == S_FINISH);
        end
    end

    assign mul_if.product  = product_q;
    assign mul_if.result   = product_q[WIDTH-1:0];
    assign mul_if.overflow = ovf_q;
    assign mul_if.busy     = busy_q;
    assign mul_if.done     = done_q;

endmodule

// File: tb/tb_signed_mult_sequencer.sv
// Directed, table-driven bench for signed_mult_sequencer.
module tb_signed_mult_sequencer;

    logic clk;
    logic rst_n;

    int total;
    int bad;

    signed_mult_sequencer_if #(.WIDTH(8)) mif ();

    signed_mult_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .mul_if (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_p;
        logic [7:0]  exp_r;
        logic        exp_ov;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Launch one operation, scramble operands after acceptance, and watch
    // 20 cycles for DONE latency and BUSY length (n=0 is the cycle after accept).
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output logic [15:0] p, output logic [7:0] r,
                          output logic ov, output int lat, output int busy_cnt);
        p = 16'h0; r = 8'h0; ov = 1'b0; lat = -1; busy_cnt = 0;
        @(negedge clk);
        mif.start = 1'b1; mif.opa = a; mif.opb = b;
        @(negedge clk);
        mif.start = 1'b0; mif.opa = ~a; mif.opb = 8'h5A;
        for (int n = 0; n < 20; n++) begin
            if (n > 0) @(negedge clk);
            if (mif.busy) busy_cnt++;
            if (mif.done && lat < 0) begin
                lat = n; p = mif.product; r = mif.result; ov = mif.overflow;
            end
        end
    endtask

    logic [15:0] p;
    logic [7:0]  r;
    logic        ov;
    int          lat;
    int          bc;
    int          done_seen;
    int          last_done;

    initial begin
        total = 0; bad = 0;
        mif.start = 1'b0; mif.opa = 8'h00; mif.opb = 8'h00;

        vecs[0] = '{8'h03, 8'h05, 16'h000F, 8'h0F, 1'b0};
        vecs[1] = '{8'hFD, 8'h05, 16'hFFF1, 8'hF1, 1'b0};
        vecs[2] = '{8'h80, 8'h80, 16'h4000, 8'h00, 1'b1};
        vecs[3] = '{8'h7F, 8'h02, 16'h00FE, 8'hFE, 1'b1};
        vecs[4] = '{8'h00, 8'h7F, 16'h0000, 8'h00, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 16'h0001, 8'h01, 1'b0};
        vecs[6] = '{8'h80, 8'h01, 16'hFF80, 8'h80, 1'b0};
        vecs[7] = '{8'h0C, 8'hF6, 16'hFF88, 8'h88, 1'b0};
        vecs[8] = '{8'h10, 8'h10, 16'h0100, 8'h00, 1'b1};

        // Reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(mif.busy), 32'd0);
        check("rst_done", 32'(mif.done), 32'd0);
        check("rst_product", 32'(mif.product), 32'd0);
        check("rst_result", 32'(mif.result), 32'd0);
        check("rst_overflow", 32'(mif.overflow), 32'd0);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, p, r, ov, lat, bc);
            check($sformatf("v%0d_product", i), 32'(p), 32'(vecs[i].exp_p));
            check($sformatf("v%0d_result", i), 32'(r), 32'(vecs[i].exp_r));
            check($sformatf("v%0d_overflow", i), 32'(ov), 32'(vecs[i].exp_ov));
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd10);
            check($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'd11);
        end

        // START held high: one operation per 12 cycles
        @(negedge clk);
        mif.start = 1'b1; mif.opa = 8'h02; mif.opb = 8'h02;
        done_seen = 0; last_done = -1;
        for (int c = 1; c <= 48; c++) begin
            @(negedge clk);
            if (mif.done) begin
                check("held_product", 32'(mif.product), 32'h0004);
                if (last_done < 0) check("held_first_done", 32'(c), 32'd11);
                else check("held_interval", 32'(c - last_done), 32'd12);
                last_done = c;
                done_seen++;
            end
        end
        check("held_done_count", 32'(done_seen), 32'd4);
        mif.start = 1'b0;
        repeat (14) @(negedge clk);

        // Reset during the 4th ITER cycle of 0x03 x 0x05
        @(negedge clk);
        mif.start = 1'b1; mif.opa = 8'h03; mif.opb = 8'h05;
        @(negedge clk);
        mif.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(mif.busy), 32'd0);
        check("abort_product", 32'(mif.product), 32'd0);
        check("abort_done", 32'(mif.done), 32'd0);
        rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mif.done) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);

        run_op(8'h03, 8'h05, p, r, ov, lat, bc);
        check("post_abort_product", 32'(p), 32'h000F);
        check("post_abort_latency", 32'(lat), 32'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
